// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, WIDTH-cycle latency.
// Define MULDIV_FAST_MUL_EN to use a single-cycle combinational multiplier for funct3 0-3.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1Data,
    input  logic [WIDTH-1:0] rs2Data,
    input  logic [4:0]       rdAddr,
    output logic             stall,
    output logic             busy,
    output logic             wbValid,
    output logic [4:0]       wbReg,
    output logic [WIDTH-1:0] wbData
);

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [2:0]       op;
    logic [4:0]       rdLat;
    logic             negA, negB;
    logic [WIDTH-1:0] magA, magB, accHi, accLo;

    logic             signA, signB, inNegA, inNegB;
    logic             divZero, divOvf, fastMul, immediate;
    logic [WIDTH-1:0] inMagA, inMagB, immRes, fastRes;
    logic [WIDTH:0]   mulSum, divShift, divDiff;
    logic [WIDTH-1:0] nextHi, nextLo;

    // Turns unsigned magnitude results {hi,lo} into the signed RV32M result for op f.
    function automatic logic [WIDTH-1:0] finalize(input logic [2:0] f, input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo, input logic nA,
                                                  input logic nB);
        logic [2*WIDTH-1:0] full;
        logic [WIDTH-1:0]   q, r;
        full = (nA ^ nB) ? -{hi, lo} : {hi, lo};
        q    = (nA ^ nB) ? -lo : lo;
        r    = nA ? -hi : hi;
        case (f)
            3'd0:             return full[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: return full[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       return q;
            default:          return r;
        endcase
    endfunction

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fastProd;
    assign fastProd = {{WIDTH{1'b0}}, inMagA} * {{WIDTH{1'b0}}, inMagB};
    assign fastMul  = !funct3[2];
    assign fastRes  = finalize(funct3, fastProd[2*WIDTH-1:WIDTH], fastProd[WIDTH-1:0], inNegA, inNegB);
`else
    assign fastMul  = 1'b0;
    assign fastRes  = '0;
`endif

    // NOTE: every always_comb output gets a value on every path; a missed branch infers a latch.
    always_comb begin
        signA     = funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
        signB     = funct3 inside {3'd1, 3'd4, 3'd6};
        inNegA    = signA & rs1Data[WIDTH-1];
        inNegB    = signB & rs2Data[WIDTH-1];
        inMagA    = inNegA ? -rs1Data : rs1Data;
        inMagB    = inNegB ? -rs2Data : rs2Data;
        divZero   = funct3[2] && (rs2Data == '0);
        divOvf    = funct3[2] && !funct3[0] && (rs1Data == MIN_NEG) && (rs2Data == '1);
        immediate = divZero | divOvf | fastMul;
        if (divZero)      immRes = funct3[1] ? rs1Data : '1;
        else if (fastMul) immRes = fastRes;
        else              immRes = funct3[1] ? '0 : MIN_NEG;
    end

    // One iteration: multiply consumes multiplier LSB first; divide shifts in dividend MSB first.
    always_comb begin
        mulSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, magA} : '0);
        divShift = {accHi, accLo[WIDTH-1]};
        divDiff  = divShift - {1'b0, magB};
        if (op[2]) begin
            if (!divDiff[WIDTH]) begin
                nextHi = divDiff[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                nextHi = divShift[WIDTH-1:0];
                nextLo = {accLo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nextHi = mulSum[WIDTH:1];
            nextLo = {mulSum[0], accLo[WIDTH-1:1]};
        end
    end

    assign stall = ((state == IDLE) && start) || (state == CALC);
    assign busy  = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            wbValid <= 1'b0;
            wbReg   <= '0;
            wbData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wbValid <= 1'b0;
                    if (start) begin
                        count <= '0;
                        if (immediate) begin
                            state   <= DONE;
                            wbValid <= (rdAddr != '0);
                            wbReg   <= rdAddr;
                            wbData  <= immRes;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        state   <= DONE;
                        wbValid <= (rdLat != '0);
                        wbReg   <= rdLat;
                        wbData  <= finalize(op, nextHi, nextLo, negA, negB);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    wbValid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op    <= funct3;
            rdLat <= rdAddr;
            negA  <= inNegA;
            negB  <= inNegB;
            magA  <= inMagA;
            magB  <= inMagB;
            accHi <= '0;
            accLo <= funct3[2] ? inMagA : inMagB;
        end else if (state == CALC) begin
            accHi <= nextHi;
            accLo <= nextLo;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus per-cycle stall/busy/writeback checks.
module tb_muldiv_unit;

    localparam int          W    = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  funct3;
    logic [31:0] rs1Data, rs2Data;
    logic [4:0]  rdAddr;
    logic        stall, busy, wbValid;
    logic [4:0]  wbReg;
    logic [31:0] wbData;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Current expected transaction: accept cycle, latency, cut-off by reset, rd and result.
    logic        recActive;
    int          recAcc, recLat, recCut;
    logic [4:0]  recRd;
    logic [31:0] recData;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic [31:0] lit;
        bit          useLit;
        bit          gap;
    } vec_t;

    vec_t vecs[20];

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3),
        .rs1Data(rs1Data), .rs2Data(rs2Data), .rdAddr(rdAddr),
        .stall(stall), .busy(busy), .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, ua, sb, ub, p;
        int ia, ib;
        sa = {{32{a[31]}}, a};
        ua = {32'h0, a};
        sb = {{32{b[31]}}, b};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MINV && b == 32'hFFFF_FFFF) return MINV;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MINV && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return W + 1;
    endfunction

    // Compare process: checks handshake outputs every cycle and the writeback in the DONE cycle.
    initial begin : compare
        logic expStall, expBusy, expDone;
        forever begin
            @(negedge clk);
            #3;
            expStall = recActive && cyc >= recAcc && cyc <= recAcc + recLat - 1 && cyc <= recCut;
            expBusy  = recActive && cyc >= recAcc + 1 && cyc <= recAcc + recLat && cyc <= recCut;
            expDone  = recActive && cyc == recAcc + recLat && cyc <= recCut;
            check("stall", {31'b0, stall}, {31'b0, expStall});
            check("busy", {31'b0, busy}, {31'b0, expBusy});
            check("wbValid", {31'b0, wbValid}, {31'b0, expDone && recRd != 0});
            if (expDone && recRd != 0) begin
                check("wbReg", {27'b0, wbReg}, {27'b0, recRd});
                check("wbData", wbData, recData);
            end
        end
    end

    task automatic issue(input vec_t v);
        funct3    = v.f;
        rs1Data   = v.a;
        rs2Data   = v.b;
        rdAddr    = v.rd;
        start     = 1'b1;
        recActive = 1'b1;
        recAcc    = cyc;
        recLat    = model_lat(v.f, v.a, v.b);
        recCut    = 1 << 30;
        recRd     = v.rd;
        recData   = model(v.f, v.a, v.b);
    endtask

    task automatic run_op(input vec_t v);
        int lat;
        issue(v);
        lat = recLat;
        repeat (lat) @(negedge clk);
        #3;
        if (v.useLit) check("literal_result", wbData, v.lit);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : main
        vec_t rv;
        rst = 1'b1; start = 1'b0; funct3 = '0; rs1Data = '0; rs2Data = '0; rdAddr = '0;
        recActive = 1'b0; recAcc = 0; recLat = 0; recCut = 0; recRd = '0; recData = '0;

        //          f     a             b             rd     literal       lit  gap
        vecs[0]  = '{3'd0, 32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b1, 1'b1};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 1'b1, 1'b1};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0,         1'b1, 1'b1};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         5'd8,  32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[4]  = '{3'd1, MINV,          MINV,          5'd9,  32'h4000_0000, 1'b1, 1'b1};
        vecs[5]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFD, 1'b1, 1'b1};
        vecs[6]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[7]  = '{3'd5, 32'd100,       32'd7,         5'd12, 32'd14,        1'b1, 1'b1};
        vecs[8]  = '{3'd7, 32'd100,       32'd7,         5'd13, 32'd2,         1'b1, 1'b1};
        vecs[9]  = '{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd14, 32'hFFFF_FFFD, 1'b1, 1'b1};
        vecs[10] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 5'd15, 32'd1,         1'b1, 1'b1};
        vecs[11] = '{3'd4, 32'd42,        32'd0,         5'd16, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[12] = '{3'd6, 32'd42,        32'd0,         5'd17, 32'd42,        1'b1, 1'b1};
        vecs[13] = '{3'd5, 32'd42,        32'd0,         5'd18, 32'hFFFF_FFFF, 1'b1, 1'b1};
        vecs[14] = '{3'd4, MINV,          32'hFFFF_FFFF, 5'd19, MINV,          1'b1, 1'b1};
        vecs[15] = '{3'd6, MINV,          32'hFFFF_FFFF, 5'd20, 32'h0,         1'b1, 1'b1};
        vecs[16] = '{3'd5, 32'd9,         32'd3,         5'd0,  32'd3,         1'b0, 1'b1};
        vecs[17] = '{3'd0, 32'd6,         32'd7,         5'd21, 32'd42,        1'b1, 1'b0};
        vecs[18] = '{3'd4, 32'd100,       32'hFFFF_FFF6, 5'd22, 32'hFFFF_FFF6, 1'b1, 1'b1};
        vecs[19] = '{3'd7, MINV,          32'hFFFF_FFFF, 5'd23, MINV,          1'b1, 1'b1};

        repeat (3) @(negedge clk);
        #3;
        check("reset_wbData", wbData, 32'h0);
        check("reset_wbReg", {27'b0, wbReg}, 32'h0);
        check("reset_wbValid", {31'b0, wbValid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // A cleared gap flag makes the next op issue in the cycle right after DONE.
        foreach (vecs[i]) begin
            run_op(vecs[i]);
            if (vecs[i].gap) @(negedge clk);
        end

        // Reset ten cycles into an iterative op: result must be discarded.
`ifdef MULDIV_FAST_MUL_EN
        rv = '{3'd5, 32'd1000, 32'd3, 5'd24, 32'd0, 1'b0, 1'b0};
`else
        rv = '{3'd0, 32'd123, 32'd456, 5'd24, 32'd0, 1'b0, 1'b0};
`endif
        issue(rv);
        repeat (10) @(negedge clk);
        rst    = 1'b1;
        start  = 1'b0;
        recCut = cyc;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("midrst_wbData", wbData, 32'h0);
        check("midrst_wbReg", {27'b0, wbReg}, 32'h0);
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
